unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined rv32i core.
- Registers each granted request and drives it onto a req/ack memory port that may take several cycles.
- Routes the read data and a completion ack back to the owning requester, and produces per-stage stall signals.
- Data has priority over fetch; a streak limit prevents fetch starvation.

---
 rtl/unified_mem_arbiter_pkg.sv | 19 +
 rtl/unified_mem_arbiter_if.sv | 52 +++++
 rtl/unified_mem_arbiter.sv | 112 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter_pkg
// Description : Shared state encoding and constants for the IF/MEM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_INSTR = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    // Instruction fetches are always full-word accesses.
    localparam logic [2:0] F3_WORD = 3'b010;

endpackage : unified_mem_arbiter_pkg
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter_if
// Description : Fetch, data and memory-port bundle around the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface unified_mem_arbiter_if
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_ack;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [2:0]            d_funct3;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_ack;

    logic                  m_req;
    logic                  m_we;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [2:0]            m_funct3;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_ack;

    logic                  stall_if;
    logic                  stall_mem;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_funct3, m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_funct3,
               stall_if, stall_mem
    );

    // Pipeline and memory side.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_funct3, m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_funct3,
               stall_if, stall_mem
    );

endinterface : unified_mem_arbiter_if
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one req/ack memory port between fetch and load/store,
//               data first with a streak limit against fetch starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
)(
    input  wire logic           clk,
    input  wire logic           rst,
    unified_mem_arbiter_if.slave bus
);

    localparam int                    c_STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DATA_STREAK);
    localparam logic [c_STREAK_W-1:0] c_STREAK_ONE = c_STREAK_W'(1);

    arb_state_t            state_q,    state_d;
    logic [c_STREAK_W-1:0] streak_q,   streak_d;
    logic                  m_req_q,    m_req_d;
    logic                  m_we_q,     m_we_d;
    logic [ADDR_WIDTH-1:0] m_addr_q,   m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q,  m_wdata_d;
    logic [2:0]            m_funct3_q, m_funct3_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            streak_q   <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_funct3_q <= 3'b000;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_funct3_q <= m_funct3_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_funct3_d = m_funct3_q;
        case (state_q)
            ARB_IDLE: begin
                m_req_d = 1'b0;
                // The streak only grows while a fetch waits, and data cannot win
                // once it reaches the limit, so it saturates without a clamp.
                if (bus.d_req && !(bus.i_req && (streak_q == c_STREAK_MAX))) begin
                    state_d    = ARB_DATA;
                    m_req_d    = 1'b1;
                    m_we_d     = bus.d_we;
                    m_addr_d   = bus.d_addr;
                    m_wdata_d  = bus.d_wdata;
                    m_funct3_d = bus.d_funct3;
                    streak_d   = bus.i_req ? (streak_q + c_STREAK_ONE) : '0;
                end else if (bus.i_req) begin
                    state_d    = ARB_INSTR;
                    m_req_d    = 1'b1;
                    m_we_d     = 1'b0;
                    m_addr_d   = bus.i_addr;
                    m_wdata_d  = '0;
                    m_funct3_d = F3_WORD;
                    streak_d   = '0;
                end
            end
            ARB_INSTR, ARB_DATA: begin
                if (bus.m_ack) begin
                    state_d = ARB_IDLE;
                    m_req_d = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_funct3  = m_funct3_q;

    // Acks and read data are steered combinationally by the current owner.
    assign bus.i_ack     = bus.m_ack && (state_q == ARB_INSTR);
    assign bus.d_ack     = bus.m_ack && (state_q == ARB_DATA);
    assign bus.i_rdata   = (state_q == ARB_INSTR) ? bus.m_rdata : '0;
    assign bus.d_rdata   = (state_q == ARB_DATA)  ? bus.m_rdata : '0;

    assign bus.stall_if  = bus.i_req && !bus.i_ack;
    assign bus.stall_mem = bus.d_req && !bus.d_ack;

endmodule : unified_mem_arbiter
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Directed self-checking bench for unified_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;
    import unified_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int   errors     = 0;
    int   checks     = 0;
    int   lat        = 1;
    int   cnt        = 0;
    int   proto_viol = 0;
    logic tie        = 1'b0;
    logic ack_r      = 1'b0;
    logic spur       = 1'b0;
    logic own_i, own_d;

    unified_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    assign bus.m_ack = tie ? bus.m_req : (ack_r | spur);

    unified_mem_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_DATA_STREAK (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: acks in the lat-th cycle of m_req; a reset abandons the access.
    always @(negedge clk) begin
        if (!rst || !bus.m_req) begin
            cnt   = 0;
            ack_r = 1'b0;
        end else begin
            cnt   = cnt + 1;
            ack_r = (cnt >= lat);
        end
    end

    // A granted requester must hold its request until the ack.
    always @(posedge clk) begin
        own_i = !bus.m_we && (bus.m_funct3 == F3_WORD) && (bus.m_addr == bus.i_addr);
        own_d = !own_i && (bus.m_addr == bus.d_addr) && (bus.m_we == bus.d_we);
        if (rst && bus.m_req && !bus.m_ack && ((own_i && !bus.i_req) || (own_d && !bus.d_req)))
            proto_viol++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0;  bus.d_wdata = '0; bus.d_funct3 = 3'b000; bus.m_rdata = '0;
        rst = 1'b0;
        step(); step();
        checks++; if ({bus.m_req, bus.m_we, bus.m_funct3} !== 5'b0) begin errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {bus.m_req, bus.m_we, bus.m_funct3}); end
        checks++; if (bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0) begin errors++;
            $display("FAIL reset_addr_wdata: got %h/%h want 0/0", bus.m_addr, bus.m_wdata); end
        checks++; if ({bus.i_ack, bus.d_ack, bus.stall_if, bus.stall_mem} !== 4'b0) begin errors++;
            $display("FAIL reset_acks: got %b want 0000", {bus.i_ack, bus.d_ack, bus.stall_if, bus.stall_mem}); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        lat = 2; bus.m_rdata = 32'h0013_0000; bus.i_addr = 32'h10; bus.i_req = 1'b1;
        #1;
        checks++; if (bus.stall_if !== 1'b1 || bus.m_req !== 1'b0) begin errors++;
            $display("FAIL fetch_pre: got stall_if=%b m_req=%b want 1/0", bus.stall_if, bus.m_req); end
        step();
        checks++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h10) begin errors++;
            $display("FAIL fetch_grant: got m_req=%b addr=%h want 1/10", bus.m_req, bus.m_addr); end
        checks++; if (bus.m_we !== 1'b0 || bus.m_funct3 !== 3'b010 || bus.i_ack !== 1'b0 || bus.stall_if !== 1'b1) begin errors++;
            $display("FAIL fetch_wait: got we=%b f3=%b i_ack=%b stall=%b want 0/010/0/1",
                     bus.m_we, bus.m_funct3, bus.i_ack, bus.stall_if); end
        step();
        checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h0013_0000) begin errors++;
            $display("FAIL fetch_ack: got i_ack=%b rdata=%h want 1/00130000", bus.i_ack, bus.i_rdata); end
        checks++; if (bus.d_ack !== 1'b0 || bus.stall_if !== 1'b0) begin errors++;
            $display("FAIL fetch_dack: got d_ack=%b stall_if=%b want 0/0", bus.d_ack, bus.stall_if); end
        bus.i_req = 1'b0;
        step();
        checks++; if (bus.m_req !== 1'b0 || bus.i_ack !== 1'b0) begin errors++;
            $display("FAIL fetch_done: got m_req=%b i_ack=%b want 0/0", bus.m_req, bus.i_ack); end
    endtask

    task automatic test_collision();
        lat = 3; bus.m_rdata = '0;
        bus.i_addr = 32'h20; bus.i_req = 1'b1;
        bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF; bus.d_funct3 = 3'b010; bus.d_req = 1'b1;
        step();
        checks++; if (bus.m_req !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 32'h100 || bus.m_wdata !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL coll_data_grant: got req=%b we=%b addr=%h wdata=%h want 1/1/100/deadbeef",
                     bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata); end
        checks++; if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b1 || bus.d_ack !== 1'b0) begin errors++;
            $display("FAIL coll_stalls: got sif=%b smem=%b d_ack=%b want 1/1/0", bus.stall_if, bus.stall_mem, bus.d_ack); end
        step();
        checks++; if (bus.d_ack !== 1'b0) begin errors++;
            $display("FAIL coll_early_ack: got %b want 0", bus.d_ack); end
        step();
        checks++; if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0) begin errors++;
            $display("FAIL coll_dack: got d_ack=%b i_ack=%b want 1/0", bus.d_ack, bus.i_ack); end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        step();
        checks++; if (bus.m_req !== 1'b0 || bus.stall_if !== 1'b1) begin errors++;
            $display("FAIL coll_gap: got m_req=%b stall_if=%b want 0/1", bus.m_req, bus.stall_if); end
        step();
        checks++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h20 || bus.m_we !== 1'b0 || bus.m_wdata !== 32'h0 || bus.m_funct3 !== 3'b010) begin errors++;
            $display("FAIL coll_fetch_grant: got req=%b addr=%h we=%b wdata=%h f3=%b want 1/20/0/0/010",
                     bus.m_req, bus.m_addr, bus.m_we, bus.m_wdata, bus.m_funct3); end
        step(); step();
        checks++; if (bus.i_ack !== 1'b1) begin errors++;
            $display("FAIL coll_iack: got %b want 1", bus.i_ack); end
        bus.i_req = 1'b0;
        step();
        checks++; if (bus.m_req !== 1'b0) begin errors++;
            $display("FAIL coll_done: got m_req=%b want 0", bus.m_req); end
    endtask

    task automatic test_streak();
        logic [31:0] exp_addr;
        lat = 1; bus.i_addr = 32'h40; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            exp_addr = ((g % 5) == 4) ? 32'h40 : 32'h200;
            step();
            checks++; if (bus.m_req !== 1'b1 || bus.m_addr !== exp_addr) begin errors++;
                $display("FAIL streak_grant%0d: got req=%b addr=%h want 1/%h", g, bus.m_req, bus.m_addr, exp_addr); end
            if (g == 9) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
            step();
            checks++; if (bus.m_req !== 1'b0) begin errors++;
                $display("FAIL streak_gap%0d: got m_req=%b want 0", g, bus.m_req); end
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_data;
        tie = 1'b1; bus.d_we = 1'b0; bus.d_funct3 = 3'b000;
        for (int k = 0; k < 3; k++) begin
            exp_data = 32'hA5A5_0000 + 32'(k);
            bus.d_addr = 32'h300 + 32'(4 * k); bus.m_rdata = exp_data; bus.d_req = 1'b1;
            step();
            checks++; if (bus.m_req !== 1'b1 || bus.d_ack !== 1'b1 || bus.d_rdata !== exp_data || bus.i_ack !== 1'b0) begin errors++;
                $display("FAIL zw_ack%0d: got req=%b d_ack=%b rdata=%h i_ack=%b want 1/1/%h/0",
                         k, bus.m_req, bus.d_ack, bus.d_rdata, bus.i_ack, exp_data); end
            checks++; if (bus.m_addr !== 32'h300 + 32'(4 * k)) begin errors++;
                $display("FAIL zw_addr%0d: got %h want %h", k, bus.m_addr, 32'h300 + 32'(4 * k)); end
            if (k == 2) bus.d_req = 1'b0;
            step();
            checks++; if (bus.m_req !== 1'b0 || bus.d_ack !== 1'b0 || bus.d_rdata !== 32'h0) begin errors++;
                $display("FAIL zw_idle%0d: got req=%b d_ack=%b rdata=%h want 0/0/0", k, bus.m_req, bus.d_ack, bus.d_rdata); end
        end
        tie = 1'b0;
    endtask

    task automatic test_async_reset();
        lat = 100; bus.d_we = 1'b0; bus.d_addr = 32'h400; bus.d_wdata = '0; bus.d_funct3 = 3'b100; bus.d_req = 1'b1;
        step();
        checks++; if (bus.m_req !== 1'b1 || bus.d_ack !== 1'b0) begin errors++;
            $display("FAIL rst_pre: got req=%b d_ack=%b want 1/0", bus.m_req, bus.d_ack); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.m_req !== 1'b0 || bus.d_ack !== 1'b0 || bus.stall_mem !== 1'b1) begin errors++;
            $display("FAIL rst_async: got req=%b d_ack=%b smem=%b want 0/0/1", bus.m_req, bus.d_ack, bus.stall_mem); end
        step();
        checks++; if (bus.m_req !== 1'b0) begin errors++;
            $display("FAIL rst_held: got m_req=%b want 0", bus.m_req); end
        rst = 1'b1; lat = 1;
        step();
        checks++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h400 || bus.m_funct3 !== 3'b100 || bus.d_ack !== 1'b1) begin errors++;
            $display("FAIL rst_regrant: got req=%b addr=%h f3=%b d_ack=%b want 1/400/100/1",
                     bus.m_req, bus.m_addr, bus.m_funct3, bus.d_ack); end
        bus.d_req = 1'b0;
        step();
        checks++; if (bus.m_req !== 1'b0) begin errors++;
            $display("FAIL rst_done: got m_req=%b want 0", bus.m_req); end
    endtask

    task automatic test_spurious();
        bus.m_rdata = 32'hFFFF_0000; spur = 1'b1;
        step();
        checks++; if ({bus.i_ack, bus.d_ack} !== 2'b00 || bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin errors++;
            $display("FAIL spur_ack: got acks=%b irdata=%h drdata=%h want 00/0/0", {bus.i_ack, bus.d_ack}, bus.i_rdata, bus.d_rdata); end
        step();
        checks++; if (bus.m_req !== 1'b0 || bus.m_addr !== 32'h400 || bus.m_funct3 !== 3'b100 || bus.m_we !== 1'b0 || bus.m_wdata !== 32'h0) begin errors++;
            $display("FAIL spur_hold: got req=%b addr=%h f3=%b we=%b wdata=%h want 0/400/100/0/0",
                     bus.m_req, bus.m_addr, bus.m_funct3, bus.m_we, bus.m_wdata); end
        spur = 1'b0; lat = 1; bus.m_rdata = 32'h0000_1234; bus.i_addr = 32'h50; bus.i_req = 1'b1;
        step();
        checks++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h50 || bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h0000_1234) begin errors++;
            $display("FAIL spur_after: got req=%b addr=%h i_ack=%b rdata=%h want 1/50/1/00001234",
                     bus.m_req, bus.m_addr, bus.i_ack, bus.i_rdata); end
        bus.i_req = 1'b0;
        step();
        checks++; if (bus.m_req !== 1'b0) begin errors++;
            $display("FAIL spur_done: got m_req=%b want 0", bus.m_req); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_collision();
        test_streak();
        test_zero_wait();
        test_async_reset();
        test_spurious();
        checks++; if (proto_viol !== 0) begin errors++;
            $display("FAIL protocol_hold: got %0d request drops want 0", proto_viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_unified_mem_arbiter
`default_nettype wire
